instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the instruction decode/control stage. Owns the PC,

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words with their PCs in a small FIFO
// and hands them to decode over a valid/ready handshake. A redirect flushes
// the buffer and marks every in-flight response as stale so it is dropped.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_DEPTH  = CW'(BUF_DEPTH);
  localparam logic [PW-1:0]   PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] pc_r, rsp_pc_r;
  logic [CW-1:0]   count_r, outstanding_r, discard_r;
  logic [PW-1:0]   head_r, tail_r;
  logic [XLEN-1:0] buf_instr_r [BUF_DEPTH];
  logic [XLEN-1:0] buf_pc_r    [BUF_DEPTH];

  logic [CW:0]     fill_s;
  logic            req_fire_s, rsp_accept_s, push_s, pop_s;
  logic [XLEN-1:0] target_s;

  // Request gating, handshakes and buffer push/pop decisions
  always_comb begin
    fill_s         = {1'b0, count_r} + {1'b0, outstanding_r};
    imem_req_valid = (state_r == ST_RUN) && (fill_s < {1'b0, CNT_DEPTH}) && !redirect_valid;
    req_fire_s     = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_accept_s   = imem_rsp_valid && (outstanding_r != CNT_ZERO);
    instr_valid    = (count_r != CNT_ZERO);
    pop_s          = instr_valid && instr_ready;
    // Kept responses land in the buffer; a full buffer only takes one alongside a pop.
    push_s         = rsp_accept_s && (discard_r == CNT_ZERO) && !redirect_valid
                     && ((count_r != CNT_DEPTH) || pop_s);
    target_s       = redirect_pc & ALIGN_MASK;
    imem_req_addr  = pc_r;
    instr          = buf_instr_r[head_r];
    instr_pc       = buf_pc_r[head_r];
  end

  // Next-state logic; a redirect cycle holds RUN/HALT so halt edges are taken next cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BOOT: state_s = ST_RUN;
      ST_RUN: begin
        if (!redirect_valid && halt) state_s = ST_HALT;
        else                         state_s = ST_RUN;
      end
      ST_HALT: begin
        if (!redirect_valid && !halt) state_s = ST_RUN;
        else                          state_s = ST_HALT;
      end
      default: state_s = ST_BOOT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_BOOT;
    else        state_r <= state_s;
  end

  // Fetch PC and the PC of the next kept response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC & ALIGN_MASK;
      rsp_pc_r <= RESET_PC & ALIGN_MASK;
    end else if (redirect_valid) begin
      pc_r     <= target_s;
      rsp_pc_r <= target_s;
    end else begin
      if (req_fire_s) pc_r     <= pc_r + PC_STEP;
      if (push_s)     rsp_pc_r <= rsp_pc_r + PC_STEP;
    end
  end

  // In-flight and stale-response counters; everything still in flight at a redirect goes stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
    end else begin
      outstanding_r <= outstanding_r + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                     - (rsp_accept_s ? CNT_ONE : CNT_ZERO);
      if (redirect_valid) begin
        discard_r <= outstanding_r - (rsp_accept_s ? CNT_ONE : CNT_ZERO);
      end else if (rsp_accept_s && (discard_r != CNT_ZERO)) begin
        discard_r <= discard_r - CNT_ONE;
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  // Buffer occupancy and pointers; redirect empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
    end else if (redirect_valid) begin
      count_r <= CNT_ZERO;
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
    end else begin
      count_r <= count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
      if (pop_s)  head_r <= head_r + PTR_ONE;
      if (push_s) tail_r <= tail_r + PTR_ONE;
    end
  end

  // Buffer storage: instruction word plus the PC it was fetched from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_r[i] <= {XLEN{1'b0}};
        buf_pc_r[i]    <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      buf_instr_r[tail_r] <= imem_rsp_data;
      buf_pc_r[tail_r]    <= rsp_pc_r;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a small in-order memory model with
// a response-hold control, plus a scoreboard of expected fetch PCs that is filled on each
// accepted request and drained whenever decode consumes an instruction.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          checks = 0;
  int          errors = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] exp_req_pc = 32'h0;
  logic [31:0] sb_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          n_req, n_pop, cyc_cnt, first_req, first_val;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic clear_logs();
    n_req = 0; n_pop = 0; cyc_cnt = 0; first_req = -1; first_val = -1;
    req_log.delete(); pop_log.delete();
  endtask

  // One clock: sample at negedge, update scoreboard and memory model after the edge.
  task automatic cyc();
    logic        live, fire, pop, redir;
    logic [31:0] a, tgt, ppc, pin, rpc;
    @(negedge clk);
    live = rst_n; fire = imem_req_valid && imem_req_ready; pop = instr_valid && instr_ready;
    redir = redirect_valid; a = imem_req_addr; tgt = redirect_pc; ppc = instr_pc; pin = instr;
    if (live && fire) begin
      checks++;
      if (imem_req_addr !== exp_req_pc) begin
        errors++; $display("FAIL req_addr got %h want %h", a, exp_req_pc);
      end
      n_req++; req_log.push_back(a);
      if (first_req < 0) first_req = cyc_cnt;
    end
    if (live && instr_valid && first_val < 0) first_val = cyc_cnt;
    if (live && pop) begin
      n_pop++; pop_log.push_back(ppc); checks++;
      if (sb_q.size() == 0) begin
        errors++; $display("FAIL unexpected_instr got pc %h want none", ppc);
      end else begin
        rpc = sb_q.pop_front();
        if (ppc !== rpc || pin !== mem_word(rpc)) begin
          errors++;
          $display("FAIL instr_out got pc %h instr %h want pc %h instr %h", ppc, pin, rpc, mem_word(rpc));
        end
      end
    end
    cyc_cnt++;
    @(posedge clk); #1;
    if (!rst_n) begin
      sb_q.delete(); mem_q.delete(); exp_req_pc = 32'h0;
    end else begin
      if (fire) mem_q.push_back(a);
      if (redir) begin
        sb_q.delete(); exp_req_pc = tgt & 32'hFFFF_FFFC;
      end else if (fire) begin
        sb_q.push_back(a); exp_req_pc = exp_req_pc + 32'd4;
      end
    end
    if (rst_n && !mem_hold && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; mem_hold = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_ready = 1'b1;
    cyc(); cyc();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h want 0", imem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr got %h/%h want 0/0", instr, instr_pc); end
    rst_n = 1'b1; clear_logs(); #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_no_req got %b want 0", imem_req_valid); end
    cyc();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL run_first_req got %b/%h want 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset(); instr_ready = 1'b1;
    run(16);
    checks++; if (first_req != 1) begin errors++; $display("FAIL first_req_cycle got %0d want 1", first_req); end
    checks++; if (first_val - first_req != 2) begin errors++; $display("FAIL fetch_latency got %0d want 2", first_val - first_req); end
    checks++;
    if (pop_log.size() < 3) begin errors++; $display("FAIL stream_pops got %0d want >=3", pop_log.size()); end
    else if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
      errors++; $display("FAIL stream_order got %h %h %h want 0 4 8", pop_log[0], pop_log[1], pop_log[2]);
    end
  endtask

  task automatic test_backpressure();
    do_reset(); instr_ready = 1'b0;
    run(10);
    checks++; if (n_req != 2) begin errors++; $display("FAIL bp_req_count got %0d want 2", n_req); end
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall got req %b valid %b want 0 1", imem_req_valid, instr_valid);
    end
    instr_ready = 1'b1; clear_logs();
    run(8);
    checks++;
    if (pop_log.size() < 2 || req_log.size() < 1) begin errors++; $display("FAIL bp_resume got pops %0d reqs %0d want >=2 >=1", pop_log.size(), req_log.size()); end
    else if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || req_log[0] !== 32'h8) begin
      errors++; $display("FAIL bp_order got %h %h req %h want 0 4 req 8", pop_log[0], pop_log[1], req_log[0]);
    end
  endtask

  task automatic test_redirect();
    do_reset(); instr_ready = 1'b0; mem_hold = 1'b1;
    for (int i = 0; i < 10 && n_req < 2; i++) cyc();
    checks++; if (n_req != 2) begin errors++; $display("FAIL redir_setup got %0d reqs want 2", n_req); end
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req got %b want 0", imem_req_valid); end
    cyc(); redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", instr_valid); end
    mem_hold = 1'b0; instr_ready = 1'b1; clear_logs();
    run(12);
    checks++;
    if (pop_log.size() < 1 || req_log.size() < 1) begin errors++; $display("FAIL redir_resume got pops %0d reqs %0d want >=1 >=1", pop_log.size(), req_log.size()); end
    else if (req_log[0] !== 32'h100 || pop_log[0] !== 32'h100) begin
      errors++; $display("FAIL redir_target got req %h pc %h want 100 100", req_log[0], pop_log[0]);
    end
  endtask

  task automatic test_misaligned_wrap();
    instr_ready = 1'b0;
    run(6);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_fill got %b want 1", instr_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    cyc(); redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL full_flush got %b want 0", instr_valid); end
    clear_logs();
    run(6);
    checks++;
    if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
      errors++; $display("FAIL align_addr got %h want 00000100", (req_log.size() > 0) ? req_log[0] : 32'hX);
    end
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc(); redirect_valid = 1'b0; clear_logs();
    run(16);
    checks++;
    if (req_log.size() < 3 || pop_log.size() < 3) begin errors++; $display("FAIL wrap_count got reqs %0d pops %0d want >=3", req_log.size(), pop_log.size()); end
    else if (req_log[0] !== 32'hFFFF_FFF8 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0 ||
             pop_log[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %h %h %h pc %h want fffffff8 fffffffc 0 pc 0",
                         req_log[0], req_log[1], req_log[2], pop_log[2]);
    end
  endtask

  task automatic test_halt();
    do_reset(); instr_ready = 1'b1;
    run(5);
    mem_hold = 1'b1; halt = 1'b1;
    cyc(); clear_logs();
    run(5);
    checks++; if (n_req != 0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL halt_no_req got %0d reqs valid %b want 0 0", n_req, imem_req_valid);
    end
    mem_hold = 1'b0;
    run(6);
    checks++; if (n_pop < 1 || sb_q.size() != 0) begin
      errors++; $display("FAIL halt_drain got pops %0d pending %0d want >=1 0", n_pop, sb_q.size());
    end
    halt = 1'b0; clear_logs();
    run(6);
    checks++;
    if (req_log.size() < 1 || req_log[0] !== 32'h10) begin
      errors++; $display("FAIL halt_resume got %h want 00000010", (req_log.size() > 0) ? req_log[0] : 32'hX);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); instr_ready = 1'b0;
    run(6);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mid_fill got %b want 1", instr_valid); end
    rst_n = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_req_addr !== 32'h0 ||
                  instr !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset got req %b valid %b addr %h instr %h pc %h want 0 0 0 0 0",
                         imem_req_valid, instr_valid, imem_req_addr, instr, instr_pc);
    end
    cyc(); rst_n = 1'b1; clear_logs();
    run(6);
    checks++;
    if (req_log.size() < 1 || req_log[0] !== 32'h0) begin
      errors++; $display("FAIL mid_restart got %h want 00000000", (req_log.size() > 0) ? req_log[0] : 32'hX);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned_wrap();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
